load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//   Memory-side counterpart to the instruction decoder's load/store outputs. Accepts one LOAD/STORE
//   (funct3, address, store data), checks alignment, drives a req/gnt/rvalid data-memory port with
//   shifted byte enables and replicated write data, then returns sign/zero-extended load data.
//   Sits between the core's execute stage and data memory. One transaction in flight at a time.
// PARAMETERS
//   data_width  32  data bus width; only 32 is supported (4 byte lanes)
//   addr_width  32  byte-address width
// PORTS
//   clk          in   1           clock, rising edge
//   rst_n        in   1           synchronous reset, active-low
//   req_valid    in   1           core request valid
//   req_ready    out  1           unit can accept a request (high only in IDLE)
//   is_load      in   1           request is a load
//   is_store     in   1           request is a store
//   funct3       in   3           instruction funct3 (width/sign select)
//   addr         in   addr_width  byte address (rs1 + imm)
//   store_data   in   32          rs2 value
//   resp_valid   out  1           one-cycle pulse: transaction complete
//   load_data    out  32          extended load result; 0 for stores and faults
//   fault        out  1           qualified by resp_valid: misaligned or illegal access
//   mem_req      out  1           memory request; held until mem_gnt
//   mem_we       out  4           byte write enables; 4'b0000 for loads
//   mem_addr     out  addr_width  word-aligned address {addr[aw-1:2],2'b00}
//   mem_wdata    out  32          lane-replicated store data
//   mem_gnt      in   1           memory accepted mem_req in this cycle
//   mem_rvalid   in   1           read data valid; earliest one cycle after gnt
//   mem_rdata    in   32          read word
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): state=IDLE; req_ready=1; resp_valid, fault, mem_req=0;
//     mem_we=0; load_data, mem_addr, mem_wdata=0.
//   FSM: IDLE -> REQ -> (store) RESP | (load) RDATA -> RESP -> IDLE; IDLE -> RESP on fault.
//   IDLE: on req_valid&&req_ready, latch all inputs. Legality check:
//     load funct3 in {000,001,010,100,101}; store funct3 in {000,001,010}; else illegal.
//     is_load==is_store (both or neither) -> illegal.
//     Halfword needs addr[0]==0. Word needs addr[1:0]==0.
//     Illegal or misaligned -> RESP with fault=1. No memory access is issued.
//   REQ: mem_req=1; mem_addr/mem_we/mem_wdata stable until the gnt cycle.
//     Store: mem_we = SB 4'b0001<<addr[1:0] | SH 4'b0011<<addr[1:0] | SW 4'b1111.
//     Store: mem_wdata = SB {4{b}} | SH {2{h}} | SW word.
//     On gnt, mem_req drops next cycle. Store -> RESP, load -> RDATA.
//   RDATA: wait any number of cycles for mem_rvalid. Then s = mem_rdata >> (8*addr[1:0]).
//     Result: LB sext(s[7:0]), LH sext(s[15:0]), LW s, LBU zext(s[7:0]), LHU zext(s[15:0]).
//     Register the result into load_data -> RESP.
//   RESP: resp_valid=1 for exactly one cycle -> IDLE.
//     load_data/fault hold their values until the next request is accepted.
//   Latency with zero-wait memory (gnt in first REQ cycle, rvalid next cycle):
//     store: accept T, mem_req T+1, resp_valid T+2.
//     load: resp_valid T+3.
//     fault: resp_valid T+1.
//   req_valid while busy: ignored, req_ready=0. Inputs are sampled only at acceptance.
//   mem_gnt outside REQ and mem_rvalid outside RDATA: ignored, no state change.
//   Reset mid-transaction: abort to IDLE; mem_req low after that edge.
//     A late gnt/rvalid in IDLE is ignored. No resp_valid for the aborted request.
// STRUCTURE
//   defines.vh: funct3 codes LB,LH,LW,LBU,LHU,SB,SH,SW; LSU state encodings IDLE/REQ/RDATA/RESP.
//   Sub-module lsu_align (combinational): store byte-enable/data replication and load
//     shift/extend; instantiated once.
//   Top module: FSM, input latches, registered outputs.
// TESTING
//   SB addr=0x1003 data=0x...A5, gnt immediate -> mem_we=1000, wdata=A5A5A5A5,
//     mem_addr=0x1000, resp_valid at T+2, fault=0.
//   LB addr=0x2001, rdata=0x1234_80FF after 3-cycle gnt delay -> load_data=0xFFFF_FF80;
//     LBU -> 0x0000_0080.
//   LH addr=0x2002, rdata=0x8001_0000 -> 0xFFFF_8001. LW addr=0x2002 -> fault=1,
//     mem_req never asserted, resp_valid at T+1.
//   Store funct3=011, and is_load=is_store=1 -> fault=1, no memory access.
//   Back-to-back req_valid held high -> second accepted only the cycle after resp_valid;
//     spurious rvalid in IDLE ignored.
//   rst_n low during RDATA -> IDLE, req_ready=1; rvalid after reset produces no resp_valid.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - funct3 codes, LSU state encodings and access legality check
package load_store_unit_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_RDATA = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   // Exactly one of load/store, a width that direction supports, and natural alignment.
   function automatic logic access_ok(input logic ld, input logic st,
                                      input logic [2:0] f3, input logic [1:0] offset);
      logic legal;
      logic aligned;
      legal = 1'b0;
      if (ld && !st)
         legal = f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      else if (st && !ld)
         legal = f3 inside {F3_SB, F3_SH, F3_SW};
      case (f3[1:0])
         2'b01:   aligned = ~offset[0];
         2'b10:   aligned = (offset == 2'b00);
         default: aligned = 1'b1;
      endcase
      return legal && aligned;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store byte-enable/lane replication and load shift/extend
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata,
   output logic [31:0] ldata
);

   logic [31:0] shifted;

   always_comb begin
      byte_en = 4'b0000;
      wdata   = 32'd0;
      ldata   = 32'd0;
      shifted = rdata >> {offset, 3'b000};

      case (funct3)
         F3_SB: begin
            byte_en = 4'b0001 << offset;
            wdata   = {4{store_data[7:0]}};
         end
         F3_SH: begin
            byte_en = 4'b0011 << offset;
            wdata   = {2{store_data[15:0]}};
         end
         default: begin
            byte_en = 4'b1111;
            wdata   = store_data;
         end
      endcase

      case (funct3)
         F3_LB:   ldata = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   ldata = {{16{shifted[15]}}, shifted[15:0]};
         F3_LBU:  ldata = {24'd0, shifted[7:0]};
         F3_LHU:  ldata = {16'd0, shifted[15:0]};
         default: ldata = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with req/gnt/rvalid memory port
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int data_width = 32,
   parameter int addr_width = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  is_load,
   input  logic                  is_store,
   input  logic [2:0]            funct3,
   input  logic [addr_width-1:0] addr,
   input  logic [data_width-1:0] store_data,
   output logic                  resp_valid,
   output logic [data_width-1:0] load_data,
   output logic                  fault,
   output logic                  mem_req,
   output logic [3:0]            mem_we,
   output logic [addr_width-1:0] mem_addr,
   output logic [data_width-1:0] mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [data_width-1:0] mem_rdata
);

   logic [1:0]  state;
   logic        lat_load;
   logic [2:0]  lat_funct3;
   logic [1:0]  lat_offset;
   logic [2:0]  sel_funct3;
   logic [1:0]  sel_offset;
   logic [3:0]  byte_en;
   logic [31:0] wdata_rep;
   logic [31:0] ldata_ext;
   logic        accept;
   logic        ok;

   assign req_ready = (state == ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign ok        = access_ok(is_load, is_store, funct3, addr[1:0]);

   // The aligner sees live inputs while idle (store setup) and latched ones afterwards (load extend).
   assign sel_funct3 = (state == ST_IDLE) ? funct3 : lat_funct3;
   assign sel_offset = (state == ST_IDLE) ? addr[1:0] : lat_offset;

   lsu_align u_align (
      .funct3     (sel_funct3),
      .offset     (sel_offset),
      .store_data (store_data),
      .rdata      (mem_rdata),
      .byte_en    (byte_en),
      .wdata      (wdata_rep),
      .ldata      (ldata_ext)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         lat_load   <= 1'b0;
         lat_funct3 <= 3'b000;
         lat_offset <= 2'b00;
         resp_valid <= 1'b0;
         load_data  <= '0;
         fault      <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 4'b0000;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  lat_load   <= is_load;
                  lat_funct3 <= funct3;
                  lat_offset <= addr[1:0];
                  load_data  <= '0;
                  fault      <= !ok;
                  if (ok) begin
                     state     <= ST_REQ;
                     mem_req   <= 1'b1;
                     mem_addr  <= {addr[addr_width-1:2], 2'b00};
                     mem_we    <= is_store ? byte_en : 4'b0000;
                     mem_wdata <= wdata_rep;
                  end else begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  if (lat_load) begin
                     state <= ST_RDATA;
                  end else begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                  end
               end
            end
            ST_RDATA: begin
               if (mem_rvalid) begin
                  load_data  <= ldata_ext;
                  state      <= ST_RESP;
                  resp_valid <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
